// File: rtl/sa_bitstream_dec.sv
// Counts the ones in a 2^len-bit stochastic bitstream and scales the count to an N-bit binary value.
// Latency: out_valid rises 1 cycle after the final bit; if the output register is blocked, the result waits in HOLD.
// Backpressure: bit_ready drops outside ACCUM and during start; a full, unaccepted output register parks the result in HOLD.
module sa_bitstream_dec #(
    parameter int N  = 7,
    parameter int LW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [LW-1:0] len_log2,
    input  logic          bit_valid,
    input  logic          bit_in,
    output logic          bit_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_value,
    output logic          out_sat,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    localparam logic [LW-1:0] N_L = LW'(N);

    state_t         state_q, state_d;
    logic [N:0]     ones_cnt_q, ones_cnt_d;
    logic [N:0]     bit_cnt_q, bit_cnt_d;
    logic [LW-1:0]  len_q, len_d;
    logic           out_valid_q, out_valid_d;
    logic [N-1:0]   out_value_q, out_value_d;
    logic           out_sat_q, out_sat_d;
    logic [N-1:0]   hold_value_q, hold_value_d;
    logic           hold_sat_q, hold_sat_d;

    logic [LW-1:0]  len_clamp;
    logic [N:0]     target;
    logic [N:0]     ones_next;
    logic [N:0]     bits_next;
    logic [N:0]     shifted;
    logic           bit_acc;
    logic           done;
    logic           can_load;
    logic           res_sat;
    logic [N-1:0]   res_value;

    assign bit_ready = (state_q == ACCUM) & ~start;
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_value = out_value_q;
    assign out_sat   = out_sat_q;

    // Datapath: stream target length, running counts and the scaled result of a completing bit.
    always_comb begin
        len_clamp = (len_log2 > N_L) ? N_L : len_log2;
        target    = {{N{1'b0}}, 1'b1} << len_q;
        bit_acc   = bit_valid & bit_ready;
        ones_next = ones_cnt_q + {{N{1'b0}}, bit_in};
        bits_next = bit_cnt_q + {{N{1'b0}}, 1'b1};
        done      = bit_acc & (bits_next == target);
        res_sat   = (ones_next == target);
        shifted   = ones_next << (N_L - len_q);
        res_value = res_sat ? {N{1'b1}} : shifted[N-1:0];
        // The output register may take a new result when empty or being drained this cycle.
        can_load  = ~out_valid_q | out_ready;
    end

    // Next-state logic: FSM transitions, counters, output register and held result.
    always_comb begin
        state_d      = state_q;
        ones_cnt_d   = ones_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        len_d        = len_q;
        out_valid_d  = out_valid_q;
        out_value_d  = out_value_q;
        out_sat_d    = out_sat_q;
        hold_value_d = hold_value_q;
        hold_sat_d   = hold_sat_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_value_d = '0;
            out_sat_d   = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = ACCUM;
                    ones_cnt_d = '0;
                    bit_cnt_d  = '0;
                    len_d      = len_clamp;
                end
            end
            ACCUM: begin
                if (start) begin
                    // Restart drops the partial stream without producing a result.
                    ones_cnt_d = '0;
                    bit_cnt_d  = '0;
                    len_d      = len_clamp;
                end else if (bit_acc) begin
                    ones_cnt_d = ones_next;
                    bit_cnt_d  = bits_next;
                    if (done) begin
                        if (can_load) begin
                            out_valid_d = 1'b1;
                            out_value_d = res_value;
                            out_sat_d   = res_sat;
                            state_d     = IDLE;
                        end else begin
                            hold_value_d = res_value;
                            hold_sat_d   = res_sat;
                            state_d      = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (can_load) begin
                    out_valid_d = 1'b1;
                    out_value_d = hold_value_q;
                    out_sat_d   = hold_sat_q;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ones_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            len_q        <= N_L;
            out_valid_q  <= 1'b0;
            out_value_q  <= '0;
            out_sat_q    <= 1'b0;
            hold_value_q <= '0;
            hold_sat_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ones_cnt_q   <= ones_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            len_q        <= len_d;
            out_valid_q  <= out_valid_d;
            out_value_q  <= out_value_d;
            out_sat_q    <= out_sat_d;
            hold_value_q <= hold_value_d;
            hold_sat_q   <= hold_sat_d;
        end
    end

endmodule

// File: tb/tb_sa_bitstream_dec.sv
// Directed bench for sa_bitstream_dec with a result-queue model and per-cycle output monitor.
// Latency: checks out_valid one cycle after the final bit; literal expectations pin key results.
// Backpressure: exercises HOLD with out_ready low, start ignored in HOLD, and async reset mid-stream.
module tb_sa_bitstream_dec;

    localparam int N  = 7;
    localparam int LW = $clog2(N + 1);
    localparam int L  = 1 << N;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [LW-1:0] len_log2;
    logic          bit_valid;
    logic          bit_in;
    logic          bit_ready;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_value;
    logic          out_sat;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    // Expected results in production order: {sat, value}.
    logic [N:0] exp_q[$];
    bit         q_bits[$];

    logic         hold_chk = 1'b0;
    logic [N-1:0] prev_value;
    logic         prev_sat;

    sa_bitstream_dec #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len_log2  (len_log2),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .bit_ready (bit_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_value (out_value),
        .out_sat   (out_sat),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference decode: value = ones * 2^N / 2^len, all-ones saturates to 2^N-1.
    function automatic logic [N:0] model(input int len, input int ones);
        int t;
        t = 1 << len;
        if (ones == t) return {1'b1, N'(L - 1)};
        return {1'b0, N'((ones * L) / t)};
    endfunction

    // Output monitor: every handshake must match the oldest expected result; held output must not change.
    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_chk) begin
                check("hold_stable_valid", 32'(out_valid), 32'd1);
                check("hold_stable_value", 32'(out_value), 32'(prev_value));
                check("hold_stable_sat", 32'(out_sat), 32'(prev_sat));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'(out_value), 32'hFFFF_FFFF);
                end else begin
                    logic [N:0] e;
                    e = exp_q.pop_front();
                    check("mon_value", 32'(out_value), 32'(e[N-1:0]));
                    check("mon_sat", 32'(out_sat), 32'(e[N]));
                end
            end
            hold_chk   = out_valid && !out_ready;
            prev_value = out_value;
            prev_sat   = out_sat;
        end else begin
            hold_chk = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int len);
        start    = 1'b1;
        len_log2 = LW'(len);
        tick();
        start    = 1'b0;
    endtask

    task automatic send_bit(input bit b);
        int n;
        n         = 0;
        bit_valid = 1'b1;
        bit_in    = b;
        forever begin
            @(negedge clk);
            if (bit_ready) break;
            n++;
            if (n > 20) begin
                check("bit_ready_timeout", 32'(bit_ready), 32'd1);
                break;
            end
        end
        tick();
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    // Sends q_bits as one stream; optionally checks no early result and records the model expectation.
    task automatic send_stream(input int len, input bit push, input bit early_chk);
        int ones;
        ones = 0;
        do_start(len);
        for (int i = 0; i < q_bits.size(); i++) begin
            if (i == q_bits.size() - 1 && early_chk)
                check("no_early_valid", 32'(out_valid), 32'd0);
            send_bit(q_bits[i]);
            if (q_bits[i]) ones++;
        end
        if (push) exp_q.push_back(model(len, ones));
    endtask

    task automatic expect_out(input string name, input int val, input int sat);
        @(negedge clk);
        check({name, "_valid"}, 32'(out_valid), 32'd1);
        check({name, "_value"}, 32'(out_value), 32'(val));
        check({name, "_sat"}, 32'(out_sat), 32'(sat));
    endtask

    task automatic gen_sa(input int k);
        int acc;
        acc = 0;
        q_bits.delete();
        for (int i = 0; i < L; i++) begin
            acc += k;
            if (acc >= L) begin
                acc -= L;
                q_bits.push_back(1'b1);
            end else begin
                q_bits.push_back(1'b0);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        len_log2  = '0;
        bit_valid = 1'b0;
        bit_in    = 1'b0;
        out_ready = 1'b1;

        // Reset state before any clock edge.
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_value", 32'(out_value), 32'd0);
        check("rst_out_sat", 32'(out_sat), 32'd0);
        check("rst_bit_ready", 32'(bit_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Bits offered in IDLE are ignored.
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        @(negedge clk);
        check("idle_bit_ready", 32'(bit_ready), 32'd0);
        tick();
        bit_valid = 1'b0;
        check("idle_no_result", 32'(out_valid), 32'd0);

        // k=32 full-length stream, latency 1.
        gen_sa(32);
        send_stream(7, 1, 1);
        expect_out("k32", 32, 0);
        tick();

        // Short len=3 stream.
        q_bits = '{1, 0, 1, 1, 0, 0, 1, 0};
        send_stream(3, 1, 1);
        expect_out("len3", 64, 0);
        tick();

        // All ones saturates.
        q_bits.delete();
        for (int i = 0; i < L; i++) q_bits.push_back(1'b1);
        send_stream(7, 1, 1);
        expect_out("all_ones", 127, 1);
        tick();

        // len=0 single bits.
        q_bits = '{0};
        send_stream(0, 1, 1);
        expect_out("len0_zero", 0, 0);
        tick();
        q_bits = '{1};
        send_stream(0, 1, 1);
        expect_out("len0_one", 127, 1);
        tick();

        // Exact decode of SA streams for several k.
        foreach (q_bits[i]) q_bits[i] = 1'b0;
        for (int j = 0; j < 4; j++) begin
            int k;
            k = (j == 0) ? 0 : (j == 1) ? 1 : (j == 2) ? 77 : 127;
            gen_sa(k);
            send_stream(7, 1, 1);
            expect_out("sa_k", k, 0);
            tick();
        end

        // Back-pressure into HOLD.
        out_ready = 1'b0;
        q_bits = '{1, 1, 1, 0};
        send_stream(2, 1, 1);
        q_bits = '{0, 1, 0, 0};
        send_stream(2, 1, 0);
        @(negedge clk);
        check("hold_busy", 32'(busy), 32'd1);
        check("hold_bit_ready", 32'(bit_ready), 32'd0);
        check("hold_value", 32'(out_value), 32'd96);
        tick();
        // start is ignored while holding.
        start    = 1'b1;
        len_log2 = 3'd1;
        tick();
        start = 1'b0;
        @(negedge clk);
        check("hold_start_busy", 32'(busy), 32'd1);
        check("hold_start_bit_ready", 32'(bit_ready), 32'd0);
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        check("hold_release_valid", 32'(out_valid), 32'd1);
        check("hold_release_value", 32'(out_value), 32'd32);
        check("hold_release_idle", 32'(busy), 32'd0);
        tick();
        out_ready = 1'b1;
        tick();
        tick();

        // Restart discards the partial stream.
        do_start(7);
        for (int i = 0; i < 10; i++) send_bit(1'b1);
        check("restart_partial_no_result", 32'(out_valid), 32'd0);
        q_bits = '{0, 0, 0, 1};
        send_stream(2, 1, 1);
        expect_out("restart", 32, 0);
        tick();
        tick();

        // Async reset mid-stream with a full output register.
        out_ready = 1'b0;
        q_bits = '{1};
        send_stream(0, 0, 1);
        do_start(7);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_bit_ready", 32'(bit_ready), 32'd0);
        check("arst_out_value", 32'(out_value), 32'd0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        q_bits = '{1, 1, 0, 0, 0, 0, 0, 0};
        send_stream(3, 1, 1);
        expect_out("post_reset", 32, 0);
        tick();
        tick();

        check("all_results_seen", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
